// File: rtl/vout_7seg_scan.sv
// Multiplexed 7-segment display driver for a signed register value.
// A sequential double-dabble engine converts the sampled value into BCD. The
// result is double-buffered and only committed at frame boundaries, so the
// digits on display always belong to a single conversion.
module vout_7seg_scan #(
  parameter int DIGITS         = 4,
  parameter int WIDTH          = 16,
  parameter int DWELL          = 256,
  parameter int BLANK          = 4,
  parameter int EN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       value,
  output logic [DIGITS-1:0] en,
  output logic [6:0]        seg,
  output logic              busy
);

  localparam int SLOT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int CNT_W  = $clog2(WIDTH);
  localparam int BCD_W  = 4 * DIGITS;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);

  localparam logic [DIGITS-1:0] EN_OFF  = (EN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0]        MINUS   = 7'h40;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

  conv_state_t       state;
  logic [WIDTH-1:0]  mag;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic              neg;
  logic              ovf;
  logic [CNT_W-1:0]  bit_cnt;

  logic [BCD_W-1:0]  res_bcd;
  logic              res_neg;
  logic              res_ovf;
  logic              result_valid;

  logic [BCD_W-1:0]  disp_bcd;
  logic              disp_neg;
  logic              disp_ovf;
  logic              disp_valid;

  logic [SLOT_W-1:0] slot;
  logic [IDX_W-1:0]  idx;
  logic              frame_wrap;

  logic [IDX_W-1:0]  msd;
  logic              ovf_eff;
  logic [3:0]        cur_digit;
  logic [6:0]        pat;
  logic [DIGITS-1:0] en_act;
  logic              blank_gap;

  // Only the low WIDTH bits of value carry information; the rest are ignored.
  logic unused_value;
  assign unused_value = ^value;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  assign frame_wrap = (slot == SLOT_LAST) && (idx == IDX_LAST);

  // Double-dabble pre-shift correction: any nibble of 5 or more gets 3 added.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // Converter FSM: sample, shift WIDTH bits through the BCD register, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      mag          <= '0;
      bcd          <= '0;
      neg          <= 1'b0;
      ovf          <= 1'b0;
      bit_cnt      <= '0;
      res_bcd      <= '0;
      res_neg      <= 1'b0;
      res_ovf      <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (frame_wrap && result_valid) begin
        result_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!result_valid) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          neg     <= value[WIDTH-1];
          mag     <= value[WIDTH-1] ? (~value[WIDTH-1:0] + 1'b1) : value[WIDTH-1:0];
          bcd     <= '0;
          ovf     <= 1'b0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          bcd     <= {bcd_adj[BCD_W-2:0], mag[WIDTH-1]};
          mag     <= mag << 1;
          ovf     <= ovf | bcd_adj[BCD_W-1];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          res_bcd      <= bcd;
          res_neg      <= neg;
          res_ovf      <= ovf;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Formats the current digit from the display buffer: leading blanks, minus sign, overflow.
  always_comb begin
    msd = '0;
    for (int k = 1; k < DIGITS; k++) begin
      if (disp_bcd[4*k +: 4] != 4'd0) begin
        msd = IDX_W'(k);
      end
    end
    ovf_eff   = disp_ovf | (disp_neg && (msd == IDX_LAST));
    cur_digit = disp_bcd[4*idx +: 4];
    if (!disp_valid) begin
      pat = 7'h00;
    end else if (ovf_eff) begin
      pat = MINUS;
    end else if (idx <= msd) begin
      pat = seg_code(cur_digit);
    end else if (disp_neg && ((IDX_W+1)'(idx) == ((IDX_W+1)'(msd) + 1'b1))) begin
      pat = MINUS;
    end else begin
      pat = 7'h00;
    end
    blank_gap = (32'(slot) < BLANK);
    if (!disp_valid || blank_gap) begin
      en_act = '0;
    end else begin
      en_act = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
    end
  end

  // Scan counters, frame-boundary commit of the result, and polarity-adjusted output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      idx        <= '0;
      disp_bcd   <= '0;
      disp_neg   <= 1'b0;
      disp_ovf   <= 1'b0;
      disp_valid <= 1'b0;
      en         <= EN_OFF;
      seg        <= SEG_OFF;
    end else begin
      en  <= (EN_ACTIVE_LOW != 0) ? ~en_act : en_act;
      seg <= (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
      if (slot == SLOT_LAST) begin
        slot <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot <= slot + 1'b1;
      end
      if (frame_wrap && result_valid) begin
        disp_bcd   <= res_bcd;
        disp_neg   <= res_neg;
        disp_ovf   <= res_ovf;
        disp_valid <= 1'b1;
      end
    end
  end

endmodule
